bus_arbiter_burst_scheduler: RTL and testbench
==============================================

Name: bus_arbiter_burst_scheduler

Overview:
- Round-robin, burst-locking scheduler that shares one downstream valid/ready bus among NUM_REQUESTS streaming requesters.
- Holds a grant for a whole burst, ending on the requester's last flag or after MAX_BURST beats, whichever comes first.
- Forwards beats through a single registered output stage.
- Sits between engine request ports and the shared memory/cache bus in the GLay overlay.

Parameters:
- NUM_REQUESTS, 4, number of requesters (>=2).
- DATA_WIDTH, 64, payload bits per beat.
- MAX_BURST, 8, maximum beats per grant (>=1).
- ID_WIDTH, $clog2(NUM_REQUESTS), grant index width.
- CNT_WIDTH, $clog2(MAX_BURST+1), beat counter width.

Ports:
- ap_clk  in  1  clock
- areset  in  1  synchronous active-high reset
- enable  in  1  permits new grants; never aborts a burst in progress
- s_valid  in  NUM_REQUESTS  per-requester beat valid
- s_data  in  [NUM_REQUESTS][DATA_WIDTH]  per-requester payload
- s_last  in  NUM_REQUESTS  per-requester end-of-burst flag
- s_ready  out  NUM_REQUESTS  per-requester accept
- m_valid  out  1  output beat valid (registered)
- m_data  out  DATA_WIDTH  output payload (registered)
- m_last  out  1  registered; high on the final beat of a grant (s_last or forced at MAX_BURST)
- m_id  out  ID_WIDTH  grantee index travelling with each beat
- m_ready  in  1  downstream accept
- busy  out  1  high while in GRANT state or while m_valid is high

Behaviour:
- Reset (synchronous, areset=1 at a rising edge):
  - State goes to IDLE; rr_ptr=0; beat_cnt=0.
  - m_valid=0, m_data=0, m_last=0, m_id=0, s_ready=0, busy=0.
  - Reset mid-burst discards the held output beat and the partial burst; there is no recovery.
- State IDLE:
  - If enable and any s_valid: pick the first requester at or above rr_ptr, wrapping modulo NUM_REQUESTS.
  - Register the pick as gnt_id, clear beat_cnt, go to GRANT.
  - Otherwise stay in IDLE.
  - s_ready is all-zero in IDLE.
- State GRANT:
  - s_ready[gnt_id] = ~m_valid | m_ready; all other s_ready bits are 0.
  - Beat accepted when s_valid[gnt_id] & s_ready[gnt_id]:
    - Load m_data, m_id and m_valid=1.
    - m_last = s_last[gnt_id] | (beat_cnt == MAX_BURST-1).
    - beat_cnt increments.
  - If m_ready & m_valid with no new accept, m_valid clears next cycle.
  - When the accepted beat has m_last set: rr_ptr = (gnt_id+1) mod NUM_REQUESTS, state returns to IDLE in the next cycle.
  - The output register may still hold that last beat after the state change; it drains normally.
- Latency and throughput:
  - First beat appears on m_valid 2 cycles after s_valid rises when in IDLE (1 cycle arbitration, 1 cycle output register).
  - Steady state is 1 beat per cycle while m_ready=1.
  - One bubble cycle between consecutive grants.
- Boundaries:
  - Grantee drops s_valid mid-burst: grant stays held, no timeout, no new arbitration.
  - MAX_BURST=1: every beat is its own grant, with forced m_last.
  - rr_ptr wraps from NUM_REQUESTS-1 to 0.
  - enable low in GRANT: the burst completes, then the block stays in IDLE.
  - s_last and the MAX_BURST limit on the same beat: a single release, no double increment of rr_ptr.
  - m_ready held low: s_ready[gnt_id] stays low once m_valid=1; no beat is lost or duplicated.
  - All s_valid high: strict rotation 0,1,2,3,0...

Optional Feature:
- Macro: BUS_ARBITER_BURST_SCHEDULER_STATS_EN.
- Defined:
  - Adds output grant_cnt [NUM_REQUESTS][32] and output beat_total [32].
  - Both are saturating counters, cleared by areset.
  - grant_cnt[i] increments on each IDLE->GRANT transition for requester i.
  - beat_total increments on each m_valid & m_ready.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package GLAY_ARBITER_PKG:
  - typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_sched_state_t.
  - typedef struct packed {data, last, id} arb_beat_t.
  - Localparam default MAX_BURST.
- Sub-module: arbiter_rr_select (combinational).
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, encoded id, valid.
  - Unit-testable standalone.

Test Plan:
- Reset then single requester: s_valid[2]=1, 3 beats D0..D2, s_last on D2, m_ready=1 -> m_id=2, beats on m_data in cycles 2..4, m_last only on D2, returns to IDLE, rr_ptr=3.
- All 4 requesting with 1-beat bursts -> grant order 0,1,2,3,0; one bubble cycle between grants.
- MAX_BURST=8, requester 1 streams 20 beats with no s_last -> m_last forced on beats 8 and 16; requester 1 is regranted only after the others are served.
- m_ready toggles 1,0,0,1 during a burst -> m_data stable while stalled; beat count in equals beat count out, same order.
- enable dropped on beat 2 of a 5-beat burst -> all 5 beats complete, no new grant while enable=0.
- areset asserted mid-burst with m_valid=1 -> next cycle all outputs 0 and state IDLE; re-arbitration starts from requester 0.

Source files
------------

// File: rtl/bus_arbiter_burst_scheduler_pkg.sv
// Shared types and defaults for the GLay burst-locking bus arbiter.
// Optional statistics are enabled with BUS_ARBITER_BURST_SCHEDULER_STATS_EN.
package glay_arbiter_pkg;

   localparam int ARB_MAX_BURST  = 8;
   localparam int ARB_DATA_WIDTH = 64;
   localparam int ARB_ID_WIDTH   = 2;

   typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_sched_state_t;

   // Beat layout at the default widths, for code that carries a whole beat as one word.
   typedef struct packed {
      logic [ARB_DATA_WIDTH-1:0] data;
      logic                      last;
      logic [ARB_ID_WIDTH-1:0]   id;
   } arb_beat_t;

   // Round-robin successor; works for requester counts that are not powers of two.
   function automatic int arbNextPtr(input int id, input int numRequests);
      return (id >= numRequests - 1) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/bus_arbiter_burst_scheduler_rr_select.sv
// Combinational round-robin pick: first requester at or above the pointer, wrapping.
module arbiter_rr_select #(
   parameter int NUM_REQUESTS = 4,
   parameter int ID_WIDTH     = $clog2(NUM_REQUESTS)
) (
   input  logic [NUM_REQUESTS-1:0] i_req,
   input  logic [ID_WIDTH-1:0]     i_rrPtr,
   output logic [NUM_REQUESTS-1:0] o_grant,
   output logic [ID_WIDTH-1:0]     o_id,
   output logic                    o_valid
);

   int                  w_idx;
   logic [ID_WIDTH-1:0] w_idxSel;

   always_comb begin
      o_grant  = '0;
      o_id     = '0;
      o_valid  = 1'b0;
      w_idx    = 0;
      w_idxSel = '0;
      for (int k = 0; k < NUM_REQUESTS; k++) begin
         w_idx = int'(i_rrPtr) + k;
         if (w_idx >= NUM_REQUESTS) begin
            w_idx = w_idx - NUM_REQUESTS;
         end
         w_idxSel = ID_WIDTH'(w_idx);
         if (!o_valid && i_req[w_idxSel]) begin
            o_valid           = 1'b1;
            o_id              = w_idxSel;
            o_grant[w_idxSel] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_burst_scheduler.sv
// Round-robin burst-locking scheduler onto one registered valid/ready bus.
// Define BUS_ARBITER_BURST_SCHEDULER_STATS_EN to add grant_cnt/beat_total counters.
module bus_arbiter_burst_scheduler
   import glay_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTS = 4,
   parameter int DATA_WIDTH   = 64,
   parameter int MAX_BURST    = ARB_MAX_BURST,
   parameter int ID_WIDTH     = $clog2(NUM_REQUESTS),
   parameter int CNT_WIDTH    = $clog2(MAX_BURST + 1)
) (
   input  logic                                   ap_clk,
   input  logic                                   areset,
   input  logic                                   enable,
   input  logic [NUM_REQUESTS-1:0]                s_valid,
   input  logic [NUM_REQUESTS-1:0][DATA_WIDTH-1:0] s_data,
   input  logic [NUM_REQUESTS-1:0]                s_last,
   output logic [NUM_REQUESTS-1:0]                s_ready,
   output logic                                   m_valid,
   output logic [DATA_WIDTH-1:0]                  m_data,
   output logic                                   m_last,
   output logic [ID_WIDTH-1:0]                    m_id,
   input  logic                                   m_ready,
   output logic                                   busy
`ifdef BUS_ARBITER_BURST_SCHEDULER_STATS_EN
   ,
   output logic [NUM_REQUESTS-1:0][31:0]          grant_cnt,
   output logic [31:0]                            beat_total
`endif
);

   arb_sched_state_t        r_state;
   arb_sched_state_t        w_nextState;
   logic [ID_WIDTH-1:0]     r_rrPtr;
   logic [ID_WIDTH-1:0]     r_gntId;
   logic [NUM_REQUESTS-1:0] r_gntOneHot;
   logic [CNT_WIDTH-1:0]    r_beatCnt;
   logic                    r_mValid;
   logic                    r_mLast;
   logic [DATA_WIDTH-1:0]   r_mData;
   logic [ID_WIDTH-1:0]     r_mId;
   logic [NUM_REQUESTS-1:0] w_selGrant;
   logic [ID_WIDTH-1:0]     w_selId;
   logic                    w_selValid;
   logic                    w_slotFree;
   logic                    w_accept;
   logic                    w_finalBeat;
   logic                    w_startGrant;

   arbiter_rr_select #(
      .NUM_REQUESTS (NUM_REQUESTS),
      .ID_WIDTH     (ID_WIDTH)
   ) u_rrSelect (
      .i_req   (s_valid),
      .i_rrPtr (r_rrPtr),
      .o_grant (w_selGrant),
      .o_id    (w_selId),
      .o_valid (w_selValid)
   );

   // The output register can take a beat when empty or when it drains this cycle.
   assign w_slotFree   = (r_state == ARB_GRANT) && (!r_mValid || m_ready);
   assign w_accept     = w_slotFree && s_valid[r_gntId];
   assign w_finalBeat  = s_last[r_gntId] || (r_beatCnt == CNT_WIDTH'(MAX_BURST - 1));
   assign w_startGrant = (r_state == ARB_IDLE) && enable && w_selValid;

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ARB_IDLE:  if (w_startGrant) w_nextState = ARB_GRANT;
         ARB_GRANT: if (w_accept && w_finalBeat) w_nextState = ARB_IDLE;
         default:   w_nextState = ARB_IDLE;
      endcase
   end

   always_comb begin
      s_ready = w_slotFree ? r_gntOneHot : '0;
      busy    = (r_state == ARB_GRANT) || r_mValid;
      m_valid = r_mValid;
      m_data  = r_mData;
      m_last  = r_mLast;
      m_id    = r_mId;
   end

   // Release and pointer advance happen once, on the accepted final beat only.
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         r_rrPtr     <= '0;
         r_gntId     <= '0;
         r_gntOneHot <= '0;
         r_beatCnt   <= '0;
         r_mValid    <= 1'b0;
         r_mLast     <= 1'b0;
         r_mData     <= '0;
         r_mId       <= '0;
      end else begin
         if (w_startGrant) begin
            r_gntId     <= w_selId;
            r_gntOneHot <= w_selGrant;
            r_beatCnt   <= '0;
         end
         if (w_accept) begin
            r_mValid  <= 1'b1;
            r_mData   <= s_data[r_gntId];
            r_mId     <= r_gntId;
            r_mLast   <= w_finalBeat;
            r_beatCnt <= r_beatCnt + CNT_WIDTH'(1);
            if (w_finalBeat) begin
               r_rrPtr <= ID_WIDTH'(arbNextPtr(int'(r_gntId), NUM_REQUESTS));
            end
         end else if (m_ready) begin
            r_mValid <= 1'b0;
         end
      end
   end

`ifdef BUS_ARBITER_BURST_SCHEDULER_STATS_EN
   logic [NUM_REQUESTS-1:0][31:0] r_grantCnt;
   logic [31:0]                   r_beatTotal;

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         r_grantCnt  <= '0;
         r_beatTotal <= '0;
      end else begin
         if (w_startGrant && (r_grantCnt[w_selId] != 32'hFFFF_FFFF)) begin
            r_grantCnt[w_selId] <= r_grantCnt[w_selId] + 32'd1;
         end
         if (r_mValid && m_ready && (r_beatTotal != 32'hFFFF_FFFF)) begin
            r_beatTotal <= r_beatTotal + 32'd1;
         end
      end
   end

   assign grant_cnt  = r_grantCnt;
   assign beat_total = r_beatTotal;
`endif

endmodule

// File: tb/tb_bus_arbiter_burst_scheduler.sv
// Directed self-checking bench for bus_arbiter_burst_scheduler at default parameters.
module tb_bus_arbiter_burst_scheduler;

   logic             ap_clk = 1'b0;
   logic             areset;
   logic             enable;
   logic [3:0]       s_valid;
   logic [3:0][63:0] s_data;
   logic [3:0]       s_last;
   logic [3:0]       s_ready;
   logic             m_valid;
   logic [63:0]      m_data;
   logic             m_last;
   logic [1:0]       m_id;
   logic             m_ready;
   logic             busy;
`ifdef BUS_ARBITER_BURST_SCHEDULER_STATS_EN
   logic [3:0][31:0] grant_cnt;
   logic [31:0]      beat_total;
`endif

   int vectorsApplied = 0;
   int miscompares    = 0;

   always #5 ap_clk = ~ap_clk;

   bus_arbiter_burst_scheduler dut (
      .ap_clk     (ap_clk),
      .areset     (areset),
      .enable     (enable),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .m_id       (m_id),
      .m_ready    (m_ready),
      .busy       (busy)
`ifdef BUS_ARBITER_BURST_SCHEDULER_STATS_EN
      ,
      .grant_cnt  (grant_cnt),
      .beat_total (beat_total)
`endif
   );

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic [3:0] valid, input logic [3:0] last,
                                input logic rdy);
      enable  = en;
      s_valid = valid;
      s_last  = last;
      m_ready = rdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorsApplied++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int rotOrder[5]  = '{3, 0, 1, 2, 3};
      int burstIds[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
      int burstLen[10] = '{1, 8, 1, 1, 1, 8, 1, 1, 1, 4};
      int nBeat, burstIdx, beatInBurst, n1, expId;
      logic acc1;

      areset  = 1'b1;
      s_data  = '0;
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
      tick();
      tick();
      $display("[TB] reset state");
      checkOutput("rst_m_valid", m_valid, 0);
      checkOutput("rst_m_data", m_data, 0);
      checkOutput("rst_m_last", m_last, 0);
      checkOutput("rst_m_id", m_id, 0);
      checkOutput("rst_s_ready", s_ready, 0);
      checkOutput("rst_busy", busy, 0);
      areset = 1'b0;

      $display("[TB] single requester, three-beat burst");
      s_data[2] = 64'hA0;
      applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b1);
      tick();
      checkOutput("s1_grant_ready", s_ready, 4'b0100);
      checkOutput("s1_no_beat_yet", m_valid, 0);
      checkOutput("s1_busy", busy, 1);
      tick();
      checkOutput("s1_b0_valid", m_valid, 1);
      checkOutput("s1_b0_data", m_data, 64'hA0);
      checkOutput("s1_b0_id", m_id, 2);
      checkOutput("s1_b0_last", m_last, 0);
      s_data[2] = 64'hA1;
      tick();
      checkOutput("s1_b1_data", m_data, 64'hA1);
      checkOutput("s1_b1_last", m_last, 0);
      s_data[2] = 64'hA2;
      applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b1);
      tick();
      checkOutput("s1_b2_data", m_data, 64'hA2);
      checkOutput("s1_b2_last", m_last, 1);
      checkOutput("s1_idle_ready", s_ready, 0);
      checkOutput("s1_drain_busy", busy, 1);
      applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
      tick();
      checkOutput("s1_drained_valid", m_valid, 0);
      checkOutput("s1_drained_busy", busy, 0);

      $display("[TB] all requesters, single-beat bursts");
      for (int i = 0; i < 4; i++) s_data[i] = 64'hB0 + 64'(i);
      applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1);
      for (int g = 0; g < 5; g++) begin
         tick();
         checkOutput("s2_bubble", m_valid, 0);
         tick();
         checkOutput("s2_valid", m_valid, 1);
         checkOutput("s2_id", m_id, 64'(rotOrder[g]));
         checkOutput("s2_data", m_data, 64'hB0 + 64'(rotOrder[g]));
         checkOutput("s2_last", m_last, 1);
      end
      applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
      tick();
      checkOutput("s2_drained", m_valid, 0);

      $display("[TB] long stream on requester 1 with forced burst ends");
      s_data[0] = 64'hC0;
      s_data[1] = 64'h100;
      s_data[2] = 64'hC2;
      s_data[3] = 64'hC3;
      applyStimulus(1'b1, 4'b1111, 4'b1101, 1'b1);
      nBeat = 0; burstIdx = 0; beatInBurst = 0; n1 = 0;
      for (int cyc = 0; cyc < 200 && nBeat < 27; cyc++) begin
         @(negedge ap_clk);
         acc1 = s_ready[1] & s_valid[1];
         tick();
         if (acc1) begin
            s_data[1] = s_data[1] + 64'd1;
            s_last[1] = (s_data[1] == 64'h113);
         end
         if (m_valid) begin
            expId = burstIds[burstIdx];
            checkOutput("s3_id", m_id, 64'(expId));
            checkOutput("s3_data", m_data, (expId == 1) ? 64'h100 + 64'(n1) : 64'hC0 + 64'(expId));
            checkOutput("s3_last", m_last, 64'(beatInBurst == burstLen[burstIdx] - 1));
            if (expId == 1) n1++;
            beatInBurst++;
            if (beatInBurst == burstLen[burstIdx]) begin
               burstIdx++;
               beatInBurst = 0;
            end
            nBeat++;
            if (nBeat == 27) applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
         end
      end
      checkOutput("s3_beat_count", 64'(nBeat), 27);
      applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
      tick();
      checkOutput("s3_drained", m_valid, 0);

      $display("[TB] downstream stall during a burst");
      s_data[2] = 64'hD0;
      applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b1);
      tick();
      checkOutput("s4_grant_ready", s_ready, 4'b0100);
      tick();
      checkOutput("s4_b0_data", m_data, 64'hD0);
      s_data[2] = 64'hD1;
      applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0);
      checkOutput("s4_stall_ready", s_ready, 0);
      tick();
      checkOutput("s4_hold1_valid", m_valid, 1);
      checkOutput("s4_hold1_data", m_data, 64'hD0);
      tick();
      checkOutput("s4_hold2_data", m_data, 64'hD0);
      checkOutput("s4_hold2_ready", s_ready, 0);
      applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b1);
      checkOutput("s4_resume_ready", s_ready, 4'b0100);
      tick();
      checkOutput("s4_b1_data", m_data, 64'hD1);
      s_data[2] = 64'hD2;
      tick();
      checkOutput("s4_b2_data", m_data, 64'hD2);
      s_data[2] = 64'hD3;
      applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b1);
      tick();
      checkOutput("s4_b3_data", m_data, 64'hD3);
      checkOutput("s4_b3_last", m_last, 1);
      applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
      tick();
      checkOutput("s4_drained", m_valid, 0);

      $display("[TB] enable dropped mid-burst");
      s_data[3] = 64'hE0;
      s_data[0] = 64'hF0;
      applyStimulus(1'b1, 4'b1001, 4'b0001, 1'b1);
      tick();
      checkOutput("s5_grant_ready", s_ready, 4'b1000);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput("s5_valid", m_valid, 1);
         checkOutput("s5_id", m_id, 3);
         checkOutput("s5_data", m_data, 64'hE0 + 64'(k));
         checkOutput("s5_last", m_last, 64'(k == 4));
         if (k == 1) enable = 1'b0;
         s_data[3] = 64'hE0 + 64'(k + 1);
         s_last[3] = (k == 3);
      end
      applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1);
      tick();
      checkOutput("s5_idle_valid", m_valid, 0);
      checkOutput("s5_idle_busy", busy, 0);
      tick();
      checkOutput("s5_idle_ready", s_ready, 0);
      checkOutput("s5_idle_busy2", busy, 0);
      applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b1);
      tick();
      checkOutput("s5_regrant_ready", s_ready, 4'b0001);
      tick();
      checkOutput("s5_regrant_id", m_id, 0);
      checkOutput("s5_regrant_data", m_data, 64'hF0);
      checkOutput("s5_regrant_last", m_last, 1);
      applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
      tick();

      $display("[TB] reset mid-burst");
      s_data[1] = 64'h77;
      applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b0);
      tick();
      checkOutput("s6_grant_ready", s_ready, 4'b0010);
      tick();
      checkOutput("s6_held_valid", m_valid, 1);
      checkOutput("s6_held_data", m_data, 64'h77);
      areset = 1'b1;
      tick();
      checkOutput("s6_rst_valid", m_valid, 0);
      checkOutput("s6_rst_data", m_data, 0);
      checkOutput("s6_rst_last", m_last, 0);
      checkOutput("s6_rst_id", m_id, 0);
      checkOutput("s6_rst_ready", s_ready, 0);
      checkOutput("s6_rst_busy", busy, 0);
      areset = 1'b0;
      for (int i = 0; i < 4; i++) s_data[i] = 64'hB0 + 64'(i);
      applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1);
      tick();
      checkOutput("s6_rearb_ready", s_ready, 4'b0001);
      tick();
      checkOutput("s6_rearb_id", m_id, 0);
      checkOutput("s6_rearb_data", m_data, 64'hB0);
      applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
      tick();
      tick();
      checkOutput("s6_final_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
